// File: rtl/stream_parity_accum_pkg.sv
// rtl/stream_parity_accum_pkg.sv - shared types and parity helper for stream_parity_accum
package parity_pkg;

    // Widest beat the helper accepts; narrower beats are zero-extended,
    // which leaves their parity unchanged.
    localparam int MAX_DATA_W = 64;

    typedef logic [MAX_DATA_W-1:0] beat_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Even parity (XOR of all bits) of one beat
    function automatic logic reduce_parity(input beat_t beat);
        return ^beat;
    endfunction

endpackage

// File: rtl/stream_parity_accum_if.sv
// rtl/stream_parity_accum_if.sv - beat input and frame result streams (PARITY_CHECK_EN adds in_chk/out_err)
interface stream_parity_accum_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic              out_parity;
    logic [CNT_W-1:0]  out_beats;
    logic              out_trunc;
`ifdef PARITY_CHECK_EN
    logic              in_chk;
    logic              out_err;

    modport master (
        output in_valid, in_data, in_last, in_chk, out_ready,
        input  in_ready, out_valid, out_parity, out_beats, out_trunc, out_err
    );

    modport slave (
        input  in_valid, in_data, in_last, in_chk, out_ready,
        output in_ready, out_valid, out_parity, out_beats, out_trunc, out_err
    );
`else
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_parity, out_beats, out_trunc
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_parity, out_beats, out_trunc
    );
`endif
endinterface

// File: rtl/stream_parity_accum_parity_reduce.sv
// rtl/stream_parity_accum_parity_reduce.sv - combinational DATA_W-to-1 XOR reduction of one beat
module parity_reduce
    import parity_pkg::*;
#(
    parameter int DATA_W = 4   // must not exceed MAX_DATA_W
) (
    input  logic [DATA_W-1:0] data,
    output logic              parity
);

    // Zero-extension to beat_t does not change the XOR of the bits
    assign parity = reduce_parity(beat_t'(data));

endmodule

// File: rtl/stream_parity_accum.sv
// rtl/stream_parity_accum.sv - per-frame parity accumulator with registered result (optional PARITY_CHECK_EN)
module stream_parity_accum
    import parity_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int MAX_BEATS = 16,
    parameter int ODD       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stream_parity_accum_if.slave  bus
);

    localparam int               CNT_W   = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
    localparam logic             ODD_BIT = (ODD != 0);

    state_e           state_q;
    state_e           state_d;
    logic             acc_q;
    logic             acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    logic             ready_en_q;
    logic             bp;
    logic             accept;
    logic             force_close;
    logic             close;
    logic             acc_sum;
    logic             res_parity;

    logic             valid_q;
    logic             parity_q;
    logic [CNT_W-1:0] beats_q;
    logic             trunc_q;
`ifdef PARITY_CHECK_EN
    logic             err_q;
`endif

    parity_reduce #(
        .DATA_W (DATA_W)
    ) u_reduce (
        .data   (bus.in_data),
        .parity (bp)
    );

    // Single result register: take a beat only when the slot is free or being drained
    assign bus.in_ready = ready_en_q && (!valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // In IDLE acc/cnt are zero, so the same expressions serve the first beat of a frame
    assign cnt_inc      = cnt_q + 1'b1;
    assign force_close  = (cnt_inc == MAX_CNT);
    assign close        = accept && (bus.in_last || force_close);
    assign acc_sum      = acc_q ^ bp;
    assign res_parity   = acc_sum ^ ODD_BIT;

    // Hold in_ready low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // Frame FSM state, parity accumulator and beat counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: a closing beat always returns to IDLE with a cleared accumulator
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (accept) begin
            if (close) begin
                state_d = IDLE;
                acc_d   = 1'b0;
                cnt_d   = '0;
            end else begin
                state_d = ACCUM;
                acc_d   = acc_sum;
                cnt_d   = cnt_inc;
            end
        end
    end

    // Result register: a new load wins over a simultaneous pop, fields hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            parity_q <= 1'b0;
            beats_q  <= '0;
            trunc_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else if (close) begin
            valid_q  <= 1'b1;
            parity_q <= res_parity;
            beats_q  <= cnt_inc;
            trunc_q  <= !bus.in_last;
`ifdef PARITY_CHECK_EN
            // in_chk only carries meaning on a real frame end
            err_q    <= bus.in_last && (res_parity != bus.in_chk);
`endif
        end else if (bus.out_ready) begin
            valid_q  <= 1'b0;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_parity = parity_q;
    assign bus.out_beats  = beats_q;
    assign bus.out_trunc  = trunc_q;
`ifdef PARITY_CHECK_EN
    assign bus.out_err    = err_q;
`endif

endmodule
